// File: rtl/uart_host_pkg.sv
// rtl/uart_host_pkg.sv - shared types and codes for the UART host sequencer
// Purpose: sequencer state enum, wrapper op codes (ren_wen) and baud-rate codes.
// Ports: none (package).
package uart_host_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PULSE  = 2'b01,
        GAP    = 2'b10,
        RDWAIT = 2'b11
    } seqState_t;

    // ren_wen op codes on control[3:2]
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    // baud-rate select codes on control[1:0]
    localparam logic [1:0] RATE_DEFAULT = 2'b00;
    localparam logic [1:0] RATE_9600    = 2'b01;
    localparam logic [1:0] RATE_50000   = 2'b10;
    localparam logic [1:0] RATE_115200  = 2'b11;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/uart_host_if.sv
// rtl/uart_host_if.sv - pin bundle between the sequencer and the UART tapeout wrapper
// Purpose: groups the wrapper control/data/error pins.
// Ports: uart_control[3:0] ({ren_wen, rate}), uart_tx_data[7:0], uart_rx_data[7:0], uart_err.
// Modports: master = sequencer side, slave = wrapper side.
interface uart_host_if;

    logic [3:0] uart_control;
    logic [7:0] uart_tx_data;
    logic [7:0] uart_rx_data;
    logic       uart_err;

    modport master (
        output uart_control,
        output uart_tx_data,
        input  uart_rx_data,
        input  uart_err
    );

    modport slave (
        input  uart_control,
        input  uart_tx_data,
        output uart_rx_data,
        output uart_err
    );

endinterface

// File: rtl/uart_host_rr_arb.sv
// rtl/uart_host_rr_arb.sv - 2-way round-robin arbiter with clear override
// Purpose: picks clear, write or read while enabled; write/read ties alternate.
// Ports: clk, nReset, en (arbitrate this cycle), clrReq/wrReq/rdReq in,
//        grantClr/grantWr/grantRd out (one-hot, combinational).
module uart_host_rr_arb (
    input  logic clk,
    input  logic nReset,
    input  logic en,
    input  logic clrReq,
    input  logic wrReq,
    input  logic rdReq,
    output logic grantClr,
    output logic grantWr,
    output logic grantRd
);

    // 1 = last write/read grant went to write; resets to "read" so write wins the first tie
    logic lastWr;

    always_comb begin
        grantClr = 1'b0;
        grantWr  = 1'b0;
        grantRd  = 1'b0;
        if (en) begin
            if (clrReq) begin
                grantClr = 1'b1;
            end else if (wrReq && rdReq) begin
                grantWr = !lastWr;
                grantRd = lastWr;
            end else begin
                grantWr = wrReq;
                grantRd = rdReq;
            end
        end
    end

    // clear grants leave the write/read fairness pointer untouched
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            lastWr <= 1'b0;
        end else if (grantWr) begin
            lastWr <= 1'b1;
        end else if (grantRd) begin
            lastWr <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_host_sequencer.sv
// rtl/uart_host_sequencer.sv - byte requests to UART wrapper pulse-then-idle control sequences
// Purpose: arbitrates write/read/clear requests, issues one-cycle ren_wen pulses
//          followed by idle gaps, returns read bytes and latches the baud select.
// Ports: clk, nReset; wr_valid/wr_data/wr_ready (write requester);
//        rd_req/rd_ack/rd_valid/rd_data/rd_empty (read requester); clr_req; rate_sel;
//        uart (wrapper pins, master modport); err_sticky, busy, zero_drop status.
module uart_host_sequencer
    import uart_host_pkg::*;
#(
    parameter int GapCycles = 2,
    parameter int RdLatency = 3,
    parameter int WrHold    = 3
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    output logic              rd_empty,
    input  logic              clr_req,
    input  logic [1:0]        rate_sel,
    uart_host_if.master       uart,
    output logic              err_sticky,
    output logic              busy,
    output logic              zero_drop
);

    localparam int CntMax = maxOf3(GapCycles, RdLatency, WrHold);
    localparam int CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] CntTop   = CntW'(CntMax);
    localparam logic [CntW-1:0] GapEnd   = CntW'(GapCycles);
    localparam logic [CntW-1:0] RdEnd    = CntW'(RdLatency);
    localparam logic [CntW-1:0] HoldLoad = CntW'(WrHold);

    seqState_t       state;
    seqState_t       stateNext;
    logic [1:0]      opReg;
    logic [1:0]      rateReg;
    logic [7:0]      txReg;
    logic [CntW-1:0] phaseCnt;   // cycles elapsed since the PULSE cycle
    logic [CntW-1:0] holdCnt;    // remaining tx hold cycles after PULSE
    logic            grantClr;
    logic            grantWr;
    logic            grantRd;
    logic            inIdle;
    logic            wrZero;
    logic            gapDone;
    logic            rdDone;
    logic            clearDone;

    assign inIdle    = (state == IDLE);
    assign wrZero    = (wr_data == 8'h00);
    assign gapDone   = (phaseCnt >= GapEnd);
    assign rdDone    = (phaseCnt >= RdEnd);
    assign clearDone = (state == GAP) && gapDone && (opReg == OP_CLR);

    uart_host_rr_arb arb (
        .clk      (clk),
        .nReset   (nReset),
        .en       (inIdle),
        .clrReq   (clr_req),
        .wrReq    (wr_valid),
        .rdReq    (rd_req),
        .grantClr (grantClr),
        .grantWr  (grantWr),
        .grantRd  (grantRd)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                // a zero-byte write is consumed here without ever reaching the wrapper
                if (grantClr || grantRd || (grantWr && !wrZero)) begin
                    stateNext = PULSE;
                end
            end
            PULSE:  stateNext = GAP;
            GAP: begin
                if (gapDone) begin
                    stateNext = (opReg == OP_RD) ? RDWAIT : IDLE;
                end
            end
            RDWAIT: begin
                if (rdDone) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign wr_ready          = grantWr;
    assign rd_ack            = grantRd;
    assign zero_drop         = grantWr && wrZero;
    assign busy              = !inIdle;
    assign uart.uart_control = {((state == PULSE) ? opReg : OP_NONE), rateReg};
    assign uart.uart_tx_data = txReg;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            opReg      <= OP_NONE;
            rateReg    <= RATE_DEFAULT;
            txReg      <= 8'h00;
            holdCnt    <= '0;
            phaseCnt   <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= 8'h00;
            rd_empty   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if (grantClr) begin
                opReg <= OP_CLR;
            end else if (grantRd) begin
                opReg <= OP_RD;
            end else if (grantWr) begin
                opReg <= OP_WR;
            end

            // baud select only moves between operations
            if (inIdle && !(grantClr || grantWr || grantRd)) begin
                rateReg <= rate_sel;
            end

            // tx byte appears with PULSE and stays for WrHold cycles after it
            if (grantWr && !wrZero) begin
                txReg   <= wr_data;
                holdCnt <= HoldLoad;
            end else if (holdCnt != '0) begin
                holdCnt <= holdCnt - CntW'(1);
            end else begin
                txReg <= 8'h00;
            end

            if (state == PULSE) begin
                phaseCnt <= CntW'(1);
            end else if (phaseCnt != CntTop) begin
                phaseCnt <= phaseCnt + CntW'(1);
            end

            rd_valid <= (state == RDWAIT) && rdDone;
            if ((state == RDWAIT) && rdDone) begin
                rd_data  <= uart.uart_rx_data;
                rd_empty <= (uart.uart_rx_data == 8'h00);
            end

            // a new error in the clearing cycle wins over the clear
            if (uart.uart_err) begin
                err_sticky <= 1'b1;
            end else if (clearDone) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_host_sequencer.md
Name: uart_host_sequencer

Overview:
- Sits between on-chip requesters and the UART tapeout wrapper's 4-bit control, tx_data and rx_data pins.
- Converts byte-level write, read and clear requests into the wrapper's required pulse-then-idle control sequences.
- Arbitrates between a write requester and a read requester.
- Holds the baud-rate select stable and changes it only between operations.

Parameters:
- GapCycles, 2, idle cycles on control[3:2] after each op pulse before the next pulse (min 1)
- RdLatency, 3, cycles from the end of a read pulse to the cycle in which uart_rx_data is sampled
- WrHold, 3, cycles tx data stays driven after a write pulse ends

Ports:
- clk  in  1  system clock
- nReset  in  1  asynchronous active-low reset
- wr_valid  in  1  write-byte request
- wr_data  in  8  byte to transmit
- wr_ready  out  1  write accepted this cycle
- rd_req  in  1  read-byte request
- rd_ack  out  1  read request accepted this cycle
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  8  byte returned from the wrapper
- rd_empty  out  1  qualifies rd_valid: returned byte was 0x00 (treated as no data)
- clr_req  in  1  request to clear both wrapper FIFOs
- rate_sel  in  2  requested baud select (00 default, 01 9600, 10 50000, 11 115200)
- uart_control  out  4  [3:2] ren_wen, [1:0] rate select to wrapper
- uart_tx_data  out  8  to wrapper tx_data
- uart_rx_data  in  8  from wrapper rx_data
- uart_err  in  1  wrapper error flag
- err_sticky  out  1  latched uart_err, cleared on clear op
- busy  out  1  state != IDLE
- zero_drop  out  1  one-cycle pulse: a 0x00 write byte was consumed without being issued

Behaviour:
- Reset values: state IDLE; all outputs 0; latched rate 00.
- State machine: IDLE, PULSE, GAP, RDWAIT.
- Op codes on ren_wen: write 01, read 10, clear 11. ren_wen is 00 in every state except PULSE.
- IDLE arbitration, evaluated only in IDLE:
  - clr_req has top priority.
  - Otherwise, if both wr_valid and rd_req are present, grant round-robin. Last-grant pointer resets to "read", so write wins the first tie.
  - The grant is registered; wr_ready or rd_ack pulses for exactly one cycle in the grant cycle.
- Rate latch: in IDLE with no grant, rate_sel is latched into control[1:0]. It is never changed in other states.
- Zero-byte write: a granted write with wr_data==0x00 pulses zero_drop and stays in IDLE (no pulse issued). The wrapper ignores zero bytes.
- PULSE: exactly 1 cycle with ren_wen = op.
  - For a write, uart_tx_data = the captured byte, held from PULSE through WrHold cycles after PULSE; otherwise it is 0.
  - Next state is GAP.
- GAP: GapCycles cycles with ren_wen=00.
  - A read moves to RDWAIT when GAP completes.
  - A write or clear returns to IDLE; the next grant can appear no earlier than the cycle after GAP ends.
  - Clear also resets err_sticky.
- RDWAIT: counts until RdLatency cycles after PULSE have elapsed.
  - In that cycle rd_data <= uart_rx_data, rd_valid=1, rd_empty=(uart_rx_data==0).
  - Then return to IDLE.
- Back-to-back write-pulse spacing is therefore 1+GapCycles cycles minimum. ren_wen never goes directly from one nonzero value to another.
- err_sticky: set whenever uart_err=1. Cleared only by a clear op, at the end of GAP; a set in the same cycle wins.
- Reset mid-op: returns to IDLE immediately and drives control=0. An in-flight read produces no rd_valid.
- Requests arriving while busy are held by the requester (valid/ready semantics). wr_data must be stable while wr_valid is high and wr_ready low.
- Counters are sized $clog2(max(GapCycles,RdLatency,WrHold)+1) and saturate at terminal values.

Decomposition:
- Package uart_host_pkg:
  - state enum
  - op codes OP_WR=2'b01, OP_RD=2'b10, OP_CLR=2'b11
  - rate codes
- Sub-module uart_host_rr_arb: 2-way round-robin arbiter with clear override and last-grant register.

Test Plan:
- Write 0x41 from idle -> control[3:2]=01 for 1 cycle, uart_tx_data=0x41 held 4 cycles, then 00 for 2 cycles; wr_ready pulses once.
- Read with uart_rx_data forced to 0x5A at pulse+3 -> rd_valid one cycle, rd_data=0x5A, rd_empty=0; with 0x00 -> rd_empty=1.
- wr_valid and rd_req held high together for 4 ops -> grants alternate W,R,W,R. Never two nonzero ren_wen cycles without a 00 gap.
- clr_req concurrent with wr_valid/rd_req -> clear granted first (ren_wen=11). err_sticky (previously set via uart_err pulse) reads 0 after the gap.
- wr_data=0x00 -> zero_drop pulses, no ren_wen activity, busy stays 0.
- rate_sel changed 00->11 during a read -> control[1:0] stays 00 until back in IDLE, then 11. Assert nReset mid-RDWAIT -> all outputs 0, no rd_valid.
